decode_sequencer: RTL

- Parametrised successor to the combinational instruction decoder.
- Buffers incoming 16-bit instructions in a DEPTH-entry FIFO and decodes the head entry into opcode/op/shift and sign-extended immediates.
- Steps the head instruction through an ordered list of register-file access slots, one slot per handshake. Each slot gives nsel, register number and read/write.
- Sits between instruction fetch and the datapath controller/register file.

---
 rtl/decode_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/decode_sequencer.sv
// Instruction FIFO plus head decoder that walks each legal instruction through
// its ordered register-file access slots, one slot per downstream handshake.
module decode_sequencer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              slot_ready,
  output logic              slot_valid,
  output logic              slot_write,
  output logic              slot_last,
  output logic [1:0]        nsel,
  output logic [2:0]        regnum,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic              illegal,
  output logic              halted,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [1:0] SEL_RN = 2'd0;
  localparam logic [1:0] SEL_RD = 2'd1;
  localparam logic [1:0] SEL_RM = 2'd2;

  typedef enum logic [1:0] {S_EMPTY, S_ISSUE, S_DISCARD, S_HALT} state_t;
  typedef enum logic [1:0] {K_LEGAL, K_ILLEGAL, K_HALT} kind_t;

  function automatic kind_t classify(input logic [15:0] w);
    case (w[15:13])
      3'b011, 3'b100, 3'b101: return K_LEGAL;
      3'b110:                 return w[11] ? K_ILLEGAL : K_LEGAL;
      3'b111:                 return K_HALT;
      default:                return K_ILLEGAL;
    endcase
  endfunction

  function automatic state_t entry_state(input kind_t k);
    case (k)
      K_LEGAL: return S_ISSUE;
      default: return S_DISCARD;
    endcase
  endfunction

  // Returns {nsel, write, last} for slot idx of a legal instruction.
  function automatic logic [3:0] slot_decode(input logic [2:0] opc, input logic [1:0] o,
                                             input logic [1:0] idx);
    logic [3:0] r;
    r = '0;
    case (opc)
      3'b110: begin
        if (o == 2'b10) r = {SEL_RN, 1'b1, 1'b1};
        else            r = (idx == 2'd0) ? {SEL_RM, 1'b0, 1'b0} : {SEL_RD, 1'b1, 1'b1};
      end
      3'b101: begin
        case (o)
          2'b01:   r = (idx == 2'd0) ? {SEL_RN, 1'b0, 1'b0} : {SEL_RM, 1'b0, 1'b1};
          2'b11:   r = (idx == 2'd0) ? {SEL_RM, 1'b0, 1'b0} : {SEL_RD, 1'b1, 1'b1};
          default: r = (idx == 2'd0) ? {SEL_RN, 1'b0, 1'b0} :
                       (idx == 2'd1) ? {SEL_RM, 1'b0, 1'b0} : {SEL_RD, 1'b1, 1'b1};
        endcase
      end
      3'b011:  r = (idx == 2'd0) ? {SEL_RN, 1'b0, 1'b0} : {SEL_RD, 1'b1, 1'b1};
      3'b100:  r = (idx == 2'd0) ? {SEL_RN, 1'b0, 1'b0} : {SEL_RD, 1'b0, 1'b1};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
    logic signed [DATA_W-1:0] s;
    s = {{(DATA_W-5){v[4]}}, v};
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    logic signed [DATA_W-1:0] s;
    s = {{(DATA_W-8){v[7]}}, v};
    return s;
  endfunction

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr;
  logic [1:0]       idx;
  state_t           state, pop_state;
  logic [15:0]      head, nxt_word;
  logic [3:0]       dec;
  logic             push, pop, full;
  logic [CNT_W-1:0] count_nxt;

  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full && !halted;
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_ISSUE && slot_valid && slot_ready && slot_last) ||
                    (state == S_DISCARD);
  assign head     = (count != '0) ? mem[rptr] : '0;

  always_comb begin
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    // With one entry left, the successor is whatever is being pushed right now.
    nxt_word  = (count == CNT_W'(1)) ? in_instr : mem[rptr + PTR_W'(1)];
    pop_state = (count_nxt == '0) ? S_EMPTY : entry_state(classify(nxt_word));
  end

  assign opcode = head[15:13];
  assign op     = head[12:11];
  assign shift  = head[4:3];
  assign sximm5 = sext5(head[4:0]);
  assign sximm8 = sext8(head[7:0]);

  assign dec        = slot_decode(head[15:13], head[12:11], idx);
  assign nsel       = slot_valid ? dec[3:2] : 2'd0;
  assign slot_write = slot_valid & dec[1];
  assign slot_last  = slot_valid & dec[0];

  always_comb begin
    regnum = 3'd0;
    if (slot_valid) begin
      case (nsel)
        SEL_RN:  regnum = head[10:8];
        SEL_RD:  regnum = head[7:5];
        SEL_RM:  regnum = head[2:0];
        default: regnum = 3'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_EMPTY;
      slot_valid <= 1'b0;
      idx        <= 2'd0;
      illegal    <= 1'b0;
      halted     <= 1'b0;
      count      <= '0;
      rptr       <= '0;
      wptr       <= '0;
    end else begin
      illegal <= 1'b0;
      count   <= count_nxt;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case (state)
        S_EMPTY: begin
          if (count != '0) begin
            state      <= entry_state(classify(head));
            slot_valid <= (classify(head) == K_LEGAL);
          end
        end
        S_ISSUE: begin
          if (slot_valid && slot_ready) begin
            if (slot_last) begin
              idx        <= 2'd0;
              state      <= pop_state;
              slot_valid <= (pop_state == S_ISSUE);
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        S_DISCARD: begin
          idx <= 2'd0;
          if (classify(head) == K_HALT) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            slot_valid <= 1'b0;
          end else begin
            illegal    <= 1'b1;
            state      <= pop_state;
            slot_valid <= (pop_state == S_ISSUE);
          end
        end
        default: ;  // HALT holds until reset
      endcase
    end
  end

endmodule
